// File: rtl/me_mem_access.sv
// ME pipeline stage: latches EX results, runs req/ack data-memory accesses, drives ME forwarding and WB write-back.
// Build option ME_MISALIGN_CHECK_EN: misaligned halfword/word accesses issue no request and pulse o_misaligned.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef INSTR_W
`define INSTR_W 32
`endif
`ifndef WORD_W
`define WORD_W 32
`endif
`ifndef MEM_OP_W
`define MEM_OP_W 4
`endif
`ifndef DEST_SRC_W
`define DEST_SRC_W 2
`endif
`ifndef REG_IDX_W
`define REG_IDX_W 5
`endif
`ifndef MEM_OP_NOP
`define MEM_OP_NOP 4'd0
`define MEM_OP_LB  4'd1
`define MEM_OP_LH  4'd2
`define MEM_OP_LW  4'd3
`define MEM_OP_LBU 4'd4
`define MEM_OP_LHU 4'd5
`define MEM_OP_SB  4'd6
`define MEM_OP_SH  4'd7
`define MEM_OP_SW  4'd8
`endif
`ifndef DEST_SRC_NONE
`define DEST_SRC_NONE 2'd0
`define DEST_SRC_ALU  2'd1
`define DEST_SRC_MEM  2'd2
`endif

module me_mem_access #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [`ADDR_W-1:0]      i_pc,
  input  logic [`INSTR_W-1:0]     i_instr,
  input  logic [`WORD_W-1:0]      i_alu_eval,
  input  logic [`WORD_W-1:0]      i_store_data,
  input  logic [`MEM_OP_W-1:0]    i_mem_op,
  input  logic [`DEST_SRC_W-1:0]  i_dest_src,
  input  logic [`REG_IDX_W-1:0]   i_dest_reg,
  output logic                    o_dm_req,
  output logic                    o_dm_we,
  output logic [`ADDR_W-1:0]      o_dm_addr,
  output logic [`WORD_W-1:0]      o_dm_wdata,
  output logic [3:0]              o_dm_be,
  input  logic                    i_dm_ack,
  input  logic [`WORD_W-1:0]      i_dm_rdata,
  output logic                    o_stall,
  output logic [`REG_IDX_W-1:0]   o_me_dest_reg,
  output logic [`DEST_SRC_W-1:0]  o_me_dest_src,
  output logic [`WORD_W-1:0]      o_me_dest_data,
  output logic                    o_wb_dest_en,
  output logic [`REG_IDX_W-1:0]   o_wb_dest_reg,
  output logic [`WORD_W-1:0]      o_wb_dest_data,
  output logic                    o_bus_err,
  output logic                    o_misaligned
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(ACK_TIMEOUT);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t                  state_reg, state_next;
  logic [7:0]              cnt_reg, cnt_next;
  logic                    done_reg, done_next;

  logic [`ADDR_W-1:0]      pc_reg;
  logic [`INSTR_W-1:0]     instr_reg;
  logic [`WORD_W-1:0]      alu_eval_reg;
  logic [`WORD_W-1:0]      store_data_reg;
  logic [`MEM_OP_W-1:0]    mem_op_reg;
  logic [`DEST_SRC_W-1:0]  dest_src_reg;
  logic [`REG_IDX_W-1:0]   dest_reg_reg;

  logic                    wb_en_reg;
  logic [`REG_IDX_W-1:0]   wb_reg_reg;
  logic [`WORD_W-1:0]      wb_data_reg;

  logic [1:0]              lane;
  logic                    is_load, is_store;
  logic                    pending, timeout, misalign, complete, me_load;
  logic [7:0]              be_wide;
  logic [`WORD_W-1:0]      wdata;
  logic [`WORD_W-1:0]      rdata_shift;
  logic [`WORD_W-1:0]      load_data;
  logic                    wb_en_next;
  logic                    unused_bits;

  assign lane = alu_eval_reg[1:0];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    case (mem_op_reg)
      `MEM_OP_LB, `MEM_OP_LH, `MEM_OP_LW, `MEM_OP_LBU, `MEM_OP_LHU: is_load = 1'b1;
      `MEM_OP_SB, `MEM_OP_SH, `MEM_OP_SW: is_store = 1'b1;
      default: ;
    endcase
  end

`ifdef ME_MISALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    case (mem_op_reg)
      `MEM_OP_LH, `MEM_OP_LHU, `MEM_OP_SH: misalign = lane[0];
      `MEM_OP_LW, `MEM_OP_SW: misalign = (lane != 2'b00);
      default: ;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  assign pending  = (mem_op_reg != `MEM_OP_NOP) & ~done_reg;
  assign timeout  = (state_reg == ST_WAIT) & (cnt_reg == TIMEOUT_CNT);
  assign o_dm_req = pending & ~misalign & ~timeout;
  // Deliberately combinational from ack so a zero-wait access never stalls.
  assign o_stall  = o_dm_req & ~i_dm_ack;
  assign complete = o_dm_req & i_dm_ack;
  assign me_load  = ~o_stall;

  assign o_bus_err    = timeout;
  assign o_misaligned = pending & misalign;

  // Byte lanes are computed 8 wide so halfwords at lane 3 simply drop the upper byte.
  always_comb begin
    be_wide = 8'h00;
    wdata   = '0;
    case (mem_op_reg)
      `MEM_OP_SB: begin
        be_wide = 8'h01 << lane;
        wdata   = {4{store_data_reg[7:0]}};
      end
      `MEM_OP_SH: begin
        be_wide = 8'h03 << lane;
        wdata   = {2{store_data_reg[15:0]}};
      end
      `MEM_OP_SW: begin
        be_wide = 8'h0F;
        wdata   = store_data_reg;
      end
      default: if (is_load) be_wide = 8'h0F;
    endcase
  end

  assign o_dm_be    = be_wide[3:0];
  assign o_dm_wdata = wdata;
  assign o_dm_we    = is_store;
  assign o_dm_addr  = {alu_eval_reg[`ADDR_W-1:2], 2'b00};

  always_comb begin
    rdata_shift = i_dm_rdata >> {lane, 3'b000};
    load_data   = rdata_shift;
    case (mem_op_reg)
      `MEM_OP_LB:  load_data = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      `MEM_OP_LH:  load_data = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      `MEM_OP_LBU: load_data = {24'h000000, rdata_shift[7:0]};
      `MEM_OP_LHU: load_data = {16'h0000, rdata_shift[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    o_me_dest_data = '0;
    case (dest_src_reg)
      `DEST_SRC_ALU: o_me_dest_data = alu_eval_reg;
      `DEST_SRC_MEM: o_me_dest_data = load_data;
      default: ;
    endcase
  end

  assign o_me_dest_reg = dest_reg_reg;
  assign o_me_dest_src = dest_src_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    done_next  = done_reg;
    case (state_reg)
      ST_IDLE: begin
        if (o_dm_req & ~i_dm_ack) begin
          state_next = ST_WAIT;
          cnt_next   = 8'd0;
        end
      end
      ST_WAIT: begin
        if (~o_dm_req | i_dm_ack) state_next = ST_IDLE;
        else                      cnt_next   = cnt_reg + 8'd1;
      end
      default: state_next = ST_IDLE;
    endcase
    if (me_load)       done_next = 1'b0;
    else if (complete) done_next = 1'b1;
  end

  // Abandoned, misaligned and store instructions never reach the register file.
  assign wb_en_next = (dest_src_reg != `DEST_SRC_NONE) & (dest_reg_reg != '0)
                    & ~timeout & ~misalign & ~is_store;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= 8'd0;
      done_reg       <= 1'b0;
      pc_reg         <= '0;
      instr_reg      <= '0;
      alu_eval_reg   <= '0;
      store_data_reg <= '0;
      mem_op_reg     <= `MEM_OP_NOP;
      dest_src_reg   <= `DEST_SRC_NONE;
      dest_reg_reg   <= '0;
      wb_en_reg      <= 1'b0;
      wb_reg_reg     <= '0;
      wb_data_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      if (me_load) begin
        pc_reg         <= i_pc;
        instr_reg      <= i_instr;
        alu_eval_reg   <= i_alu_eval;
        store_data_reg <= i_store_data;
        mem_op_reg     <= i_mem_op;
        dest_src_reg   <= i_dest_src;
        dest_reg_reg   <= i_dest_reg;
        wb_en_reg      <= wb_en_next;
        wb_reg_reg     <= dest_reg_reg;
        wb_data_reg    <= o_me_dest_data;
      end else begin
        wb_en_reg <= 1'b0;
      end
    end
  end

  assign o_wb_dest_en   = wb_en_reg;
  assign o_wb_dest_reg  = wb_reg_reg;
  assign o_wb_dest_data = wb_data_reg;

  // PC and instruction travel with the stage for debug visibility only.
  assign unused_bits = ^{pc_reg, instr_reg, be_wide[7:4]};

endmodule

// File: tb/tb_me_mem_access.sv
// Directed testbench for me_mem_access (ACK_TIMEOUT=4); hand-computed expectations, one line per transaction.
module tb_me_mem_access;

  localparam logic [3:0] OP_NOP = 4'd0, OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3,
                         OP_LBU = 4'd4, OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7,
                         OP_SW = 4'd8;
  localparam logic [1:0] SRC_NONE = 2'd0, SRC_ALU = 2'd1, SRC_MEM = 2'd2;

  logic        clk, clr;
  logic [31:0] i_pc, i_instr, i_alu_eval, i_store_data;
  logic [3:0]  i_mem_op;
  logic [1:0]  i_dest_src;
  logic [4:0]  i_dest_reg;
  logic        o_dm_req, o_dm_we;
  logic [31:0] o_dm_addr, o_dm_wdata;
  logic [3:0]  o_dm_be;
  logic        i_dm_ack;
  logic [31:0] i_dm_rdata;
  logic        o_stall;
  logic [4:0]  o_me_dest_reg;
  logic [1:0]  o_me_dest_src;
  logic [31:0] o_me_dest_data;
  logic        o_wb_dest_en;
  logic [4:0]  o_wb_dest_reg;
  logic [31:0] o_wb_dest_data;
  logic        o_bus_err, o_misaligned;

  int checks = 0;
  int errors = 0;
  int stalls;
  logic seen;

  me_mem_access #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .clr(clr),
    .i_pc(i_pc), .i_instr(i_instr), .i_alu_eval(i_alu_eval), .i_store_data(i_store_data),
    .i_mem_op(i_mem_op), .i_dest_src(i_dest_src), .i_dest_reg(i_dest_reg),
    .o_dm_req(o_dm_req), .o_dm_we(o_dm_we), .o_dm_addr(o_dm_addr),
    .o_dm_wdata(o_dm_wdata), .o_dm_be(o_dm_be),
    .i_dm_ack(i_dm_ack), .i_dm_rdata(i_dm_rdata),
    .o_stall(o_stall),
    .o_me_dest_reg(o_me_dest_reg), .o_me_dest_src(o_me_dest_src), .o_me_dest_data(o_me_dest_data),
    .o_wb_dest_en(o_wb_dest_en), .o_wb_dest_reg(o_wb_dest_reg), .o_wb_dest_data(o_wb_dest_data),
    .o_bus_err(o_bus_err), .o_misaligned(o_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=still_running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [3:0] op, input logic [1:0] src, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] sdata);
    i_mem_op     = op;
    i_dest_src   = src;
    i_dest_reg   = rd;
    i_alu_eval   = alu;
    i_store_data = sdata;
    i_pc         = i_pc + 32'd4;
    i_instr      = {alu[15:0], 7'd0, rd, op};
  endtask

  task automatic set_nop();
    set_ex(OP_NOP, SRC_NONE, 5'd0, 32'd0, 32'd0);
  endtask

  // Load acknowledged in the same cycle it is requested.
  task automatic load_zw(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [4:0] rd, input logic [31:0] raw,
                         input logic [31:0] exp_addr, input logic [31:0] exp);
    set_ex(op, SRC_MEM, rd, addr, 32'd0);
    step();
    set_nop();
    i_dm_ack   = 1'b1;
    i_dm_rdata = raw;
    #1;
    check({tag, "_req"},   o_dm_req, 1);
    check({tag, "_addr"},  o_dm_addr, exp_addr);
    check({tag, "_be"},    o_dm_be, 4'b1111);
    check({tag, "_stall"}, o_stall, 0);
    check({tag, "_fwd"},   o_me_dest_data, exp);
    step();
    i_dm_ack = 1'b0;
    check({tag, "_wben"},  o_wb_dest_en, 1);
    check({tag, "_wbreg"}, o_wb_dest_reg, rd);
    check({tag, "_wbdat"}, o_wb_dest_data, exp);
    $display("txn %s addr=0x%08h rdata=0x%08h wb=0x%08h", tag, addr, raw, o_wb_dest_data);
  endtask

  initial begin
    clr = 1'b1; i_dm_ack = 1'b0; i_dm_rdata = 32'd0; i_pc = 32'd0; i_instr = 32'd0;
    set_ex(OP_LW, SRC_MEM, 5'd3, 32'h100, 32'd0);
    step(); step();
    #1;
    check("rst_req",   o_dm_req, 0);
    check("rst_stall", o_stall, 0);
    check("rst_src",   o_me_dest_src, 0);
    check("rst_be",    o_dm_be, 0);
    check("rst_wben",  o_wb_dest_en, 0);
    check("rst_err",   o_bus_err, 0);
    $display("txn reset");
    clr = 1'b0;
    set_nop();
    step();

    load_zw("lw",  OP_LW,  32'h100, 5'd3, 32'h11223344, 32'h100, 32'h11223344);
    load_zw("lbu", OP_LBU, 32'h103, 5'd8, 32'h80AABBCC, 32'h100, 32'h00000080);
    load_zw("lh",  OP_LH,  32'h102, 5'd9, 32'h80011234, 32'h100, 32'hFFFF8001);
    load_zw("lhu", OP_LHU, 32'h102, 5'd9, 32'h80011234, 32'h100, 32'h00008001);

    // LB with wait states: three stalled cycles, then ack
    set_ex(OP_LB, SRC_MEM, 5'd7, 32'h103, 32'd0);
    step();
    set_nop();
    i_dm_rdata = 32'h80AABBCC;
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (o_stall) stalls++;
      check("lb_addr_hold", o_dm_addr, 32'h100);
      step();
      check("lb_wben_bubble", o_wb_dest_en, 0);
    end
    i_dm_ack = 1'b1;
    #1;
    check("lb_stalls", stalls, 3);
    check("lb_req", o_dm_req, 1);
    check("lb_stall_rel", o_stall, 0);
    check("lb_fwd", o_me_dest_data, 32'hFFFFFF80);
    step();
    i_dm_ack = 1'b0;
    check("lb_wben",  o_wb_dest_en, 1);
    check("lb_wbreg", o_wb_dest_reg, 5'd7);
    check("lb_wbdat", o_wb_dest_data, 32'hFFFFFF80);
    $display("txn lb addr=0x103 wait=3 wb=0x%08h", o_wb_dest_data);

    // SB at lane 2
    set_ex(OP_SB, SRC_NONE, 5'd0, 32'h202, 32'h12345678);
    step();
    set_nop();
    #1;
    check("sb_req",   o_dm_req, 1);
    check("sb_we",    o_dm_we, 1);
    check("sb_addr",  o_dm_addr, 32'h200);
    check("sb_be",    o_dm_be, 4'b0100);
    check("sb_wdata", o_dm_wdata, 32'h78787878);
    i_dm_ack = 1'b1;
    step();
    i_dm_ack = 1'b0;
    check("sb_wben", o_wb_dest_en, 0);
    $display("txn sb addr=0x202 data=0x12345678");

    // SW at word address
    set_ex(OP_SW, SRC_NONE, 5'd0, 32'h204, 32'hA5A50F0F);
    step();
    set_nop();
    i_dm_ack = 1'b1;
    #1;
    check("sw_be",    o_dm_be, 4'b1111);
    check("sw_wdata", o_dm_wdata, 32'hA5A50F0F);
    check("sw_stall", o_stall, 0);
    step();
    i_dm_ack = 1'b0;
    check("sw_wben", o_wb_dest_en, 0);
    $display("txn sw addr=0x204 data=0xa5a50f0f");

    // SH at lane 3: dropped upper lane, or suppressed when misalignment checking is built in
    set_ex(OP_SH, SRC_NONE, 5'd0, 32'h203, 32'hCAFEBEEF);
    step();
    set_nop();
    #1;
`ifdef ME_MISALIGN_CHECK_EN
    check("sh3_req",   o_dm_req, 0);
    check("sh3_mis",   o_misaligned, 1);
    check("sh3_stall", o_stall, 0);
    step();
    check("sh3_mis_end", o_misaligned, 0);
    check("sh3_wben",    o_wb_dest_en, 0);
`else
    check("sh3_req",   o_dm_req, 1);
    check("sh3_be",    o_dm_be, 4'b1000);
    check("sh3_wdata", o_dm_wdata, 32'hBEEFBEEF);
    check("sh3_mis",   o_misaligned, 0);
    i_dm_ack = 1'b1;
    step();
    i_dm_ack = 1'b0;
    check("sh3_wben", o_wb_dest_en, 0);
`endif
    $display("txn sh addr=0x203 data=0xcafebeef");

    // ALU results: x5 writes, x0 does not
    set_ex(OP_NOP, SRC_ALU, 5'd5, 32'h0000DEAD, 32'd0);
    step();
    set_ex(OP_NOP, SRC_ALU, 5'd0, 32'h0000BEEF, 32'd0);
    #1;
    check("alu_src",   o_me_dest_src, SRC_ALU);
    check("alu_fwd",   o_me_dest_data, 32'h0000DEAD);
    check("alu_stall", o_stall, 0);
    step();
    set_nop();
    check("alu_wben",  o_wb_dest_en, 1);
    check("alu_wbreg", o_wb_dest_reg, 5'd5);
    check("alu_wbdat", o_wb_dest_data, 32'h0000DEAD);
    step();
    check("alu_x0_wben", o_wb_dest_en, 0);
    $display("txn alu x5=0xdead then x0");

    // Timeout: never ack; 1 request cycle + 4 WAIT cycles stalled, then bus error
    set_ex(OP_LW, SRC_MEM, 5'd9, 32'h300, 32'd0);
    step();
    set_nop();
    stalls = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (o_bus_err) begin
        seen = 1'b1;
        check("to_req_drop", o_dm_req, 0);
        check("to_stall_rel", o_stall, 0);
      end else if (o_stall) begin
        stalls++;
      end
      step();
    end
    check("to_seen", seen, 1);
    check("to_stalls", stalls, 5);
    #1;
    check("to_err_pulse", o_bus_err, 0);
    check("to_wben", o_wb_dest_en, 0);
    i_dm_ack = 1'b1;
    #1;
    check("to_late_stall", o_stall, 0);
    step();
    i_dm_ack = 1'b0;
    check("to_late_wben", o_wb_dest_en, 0);
    $display("txn lw addr=0x300 timeout stalls=%0d", stalls);

    // clr during WAIT
    set_ex(OP_LW, SRC_MEM, 5'd4, 32'h400, 32'd0);
    step();
    set_nop();
    step();
    #1;
    check("clr_wait_req",   o_dm_req, 1);
    check("clr_wait_stall", o_stall, 1);
    clr = 1'b1;
    step();
    #1;
    check("clr_req",   o_dm_req, 0);
    check("clr_stall", o_stall, 0);
    clr = 1'b0;
    i_dm_ack = 1'b1;
    i_dm_rdata = 32'h55555555;
    step();
    i_dm_ack = 1'b0;
    check("clr_late_wben", o_wb_dest_en, 0);
    check("clr_late_err",  o_bus_err, 0);
    $display("txn lw addr=0x400 cleared mid-access");

`ifdef ME_MISALIGN_CHECK_EN
    set_ex(OP_LW, SRC_MEM, 5'd6, 32'h101, 32'd0);
    step();
    set_nop();
    #1;
    check("mis_lw_req",   o_dm_req, 0);
    check("mis_lw_flag",  o_misaligned, 1);
    check("mis_lw_stall", o_stall, 0);
    step();
    check("mis_lw_flag_end", o_misaligned, 0);
    check("mis_lw_wben",     o_wb_dest_en, 0);
    $display("txn lw addr=0x101 misaligned");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
